// File: rtl/pdp8_uart_rx_pkg.sv
// rtl/pdp8_uart_rx_pkg.sv - shared receiver state encodings and frame defaults
package pdp8_uart_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/pdp8_uart_rx_sync2.sv
// rtl/pdp8_uart_rx_sync2.sv - two-flop synchronizer with configurable reset value
module pdp8_uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pdp8_uart_rx.sv
// rtl/pdp8_uart_rx.sv - 8N1 console receiver with single-byte holding register
module pdp8_uart_rx
  import pdp8_uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_busy,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bidx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_ov;
  logic                 w_rxs;
  logic                 w_stop_pt;
  logic                 w_load;
  logic                 w_ferr;

  pdp8_uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rxd),
    .o_q     (w_rxs)
  );

  assign w_stop_pt = baud_tick && (r_state == ST_STOP) && (r_tcnt == FULL_M1);
  assign w_load    = w_stop_pt && w_rxs;
  assign w_ferr    = w_stop_pt && !w_rxs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      if (baud_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_rxs) begin
              r_state <= ST_START;
              r_tcnt  <= '0;
            end
          end
          // r_tcnt holds (ticks since phase start) - 1, so compares are one short
          ST_START: begin
            if (r_tcnt == HALF_M1) begin
              r_tcnt <= '0;
              if (w_rxs) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_DATA;
                r_bidx  <= '0;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (r_tcnt == FULL_M1) begin
              r_tcnt  <= '0;
              r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
              if (r_bidx == LAST_BIT) begin
                r_state <= ST_STOP;
              end else begin
                r_bidx <= r_bidx + 1'b1;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (r_tcnt == FULL_M1) begin
              r_tcnt  <= '0;
              r_state <= w_rxs ? ST_IDLE : ST_BREAK;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          ST_BREAK: begin
            if (w_rxs) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      // a load always wins over an ack arriving in the same cycle
      if (w_load) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
        if (rx_ack) begin
          r_ov <= 1'b0;
          r_fe <= 1'b0;
        end else if (r_valid) begin
          r_ov <= 1'b1;
        end
      end else begin
        if (rx_ack) begin
          r_valid <= 1'b0;
          r_fe    <= 1'b0;
          r_ov    <= 1'b0;
        end
        if (w_ferr) begin
          r_fe <= 1'b1;
        end
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_busy     = (r_state != ST_IDLE);
  assign framing_err = r_fe;
  assign overrun     = r_ov;

endmodule

// File: tb/tb_pdp8_uart_rx.sv
// tb/tb_pdp8_uart_rx.sv - directed frames against a tick-offset receiver model
module tb_pdp8_uart_rx;

  localparam int OS       = 16;
  localparam int HALF     = OS / 2;
  localparam int STOP_OFF = HALF + 9 * OS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun;

  int n_checks = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  // model state: mode 0 idle, 1 in frame, 2 waiting out a break
  int         m_mode;
  int         m_off;
  logic [7:0] m_byte;
  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ov, m_s1, m_s2;

  pdp8_uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_busy     (rx_busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic rxs, ld, fe_set;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_off = 0; m_byte = '0;
        m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      end else begin
        rxs = m_s2; ld = 1'b0; fe_set = 1'b0;
        if (baud_tick) begin
          if (m_mode == 0) begin
            if (!rxs) begin m_mode = 1; m_off = 0; end
          end else if (m_mode == 1) begin
            m_off++;
            if (m_off == HALF) begin
              if (rxs) m_mode = 0;
            end else if (m_off == STOP_OFF) begin
              if (rxs) ld = 1'b1; else fe_set = 1'b1;
              m_mode = rxs ? 0 : 2;
            end else if (m_off > HALF && (m_off - HALF) % OS == 0) begin
              m_byte[(m_off - HALF) / OS - 1] = rxs;
            end
          end else if (rxs) begin
            m_mode = 0;
          end
        end
        if (ld) begin
          if (rx_ack) begin m_ov = 1'b0; m_fe = 1'b0; end
          else if (m_valid) m_ov = 1'b1;
          m_data = m_byte; m_valid = 1'b1;
        end else begin
          if (rx_ack) begin m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0; end
          if (fe_set) m_fe = 1'b1;
        end
        m_s2 = m_s1; m_s1 = rxd;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp rx_valid", {31'b0, rx_valid}, {31'b0, m_valid});
      chk("cmp rx_data", {24'b0, rx_data}, {24'b0, m_data});
      chk("cmp framing_err", {31'b0, framing_err}, {31'b0, m_fe});
      chk("cmp overrun", {31'b0, overrun}, {31'b0, m_ov});
      chk("cmp rx_busy", {31'b0, rx_busy}, {31'b0, (m_mode != 0)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one bit-time sixteenth: line level held 3 clocks, baud_tick on the last
  task automatic slot(input logic lvl, input logic ack);
    rxd = lvl; baud_tick = 1'b0; rx_ack = 1'b0;
    step(); step();
    baud_tick = 1'b1; rx_ack = ack;
    step();
    baud_tick = 1'b0; rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_slot);
    logic lvl;
    for (int s = 0; s < 160; s++) begin
      if (s < 16) lvl = 1'b0;
      else if (s < 144) lvl = d[(s - 16) / 16];
      else lvl = stop;
      slot(lvl, s == ack_slot);
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
    chk(nm, {24'b0, act}, {24'b0, exp});
  endtask

  initial begin
    step(); step();
    cmp_en = 1'b1;
    @(negedge clk);
    lit("reset rx_valid", {7'b0, rx_valid}, 8'h00);
    lit("reset rx_data", rx_data, 8'h00);
    lit("reset flags", {5'b0, rx_busy, framing_err, overrun}, 8'h00);
    step();
    reset_n = 1'b1;
    idle(5);

    send_frame(8'h87, 1'b1, -1);
    @(negedge clk);
    lit("t1 rx_data", rx_data, 8'h87);
    lit("t1 rx_valid", {7'b0, rx_valid}, 8'h01);
    lit("t1 errors", {6'b0, framing_err, overrun}, 8'h00);
    step();
    ack_pulse();
    @(negedge clk);
    lit("t1 ack clears valid", {7'b0, rx_valid}, 8'h00);
    idle(3);

    for (int i = 0; i < 4; i++) slot(1'b0, 1'b0);
    @(negedge clk);
    lit("t2 busy in start", {7'b0, rx_busy}, 8'h01);
    idle(12);
    @(negedge clk);
    lit("t2 false start", {6'b0, rx_busy, rx_valid}, 8'h00);
    idle(2);

    send_frame(8'h55, 1'b0, -1);
    for (int i = 0; i < 48; i++) slot(1'b0, 1'b0);
    @(negedge clk);
    lit("t3 framing_err", {7'b0, framing_err}, 8'h01);
    lit("t3 rx_valid", {7'b0, rx_valid}, 8'h00);
    lit("t3 rx_data kept", rx_data, 8'h87);
    lit("t3 busy in break", {7'b0, rx_busy}, 8'h01);
    idle(4);
    @(negedge clk);
    lit("t3 idle after break", {7'b0, rx_busy}, 8'h00);
    send_frame(8'h0D, 1'b1, -1);
    idle(2);
    @(negedge clk);
    lit("t3 next frame", rx_data, 8'h0D);
    lit("t3 fe sticky", {6'b0, framing_err, rx_valid}, 8'h03);
    step();
    ack_pulse();
    idle(2);

    send_frame(8'h41, 1'b1, -1);
    send_frame(8'h42, 1'b1, -1);
    @(negedge clk);
    lit("t4 overrun", {6'b0, overrun, rx_valid}, 8'h03);
    lit("t4 rx_data", rx_data, 8'h42);
    step();
    ack_pulse();
    @(negedge clk);
    lit("t4 ack clears", {5'b0, rx_valid, framing_err, overrun}, 8'h00);
    step();
    idle(2);

    send_frame(8'h31, 1'b1, -1);
    send_frame(8'h8D, 1'b1, 152);
    @(negedge clk);
    lit("t5 rx_data", rx_data, 8'h8D);
    lit("t5 valid no overrun", {6'b0, rx_valid, overrun}, 8'h02);
    step();
    ack_pulse();
    idle(2);

    for (int s = 0; s < 56; s++) slot((s < 16) ? 1'b0 : 1'b1, 1'b0);
    reset_n = 1'b0;
    step(); step();
    rxd = 1'b1;
    step();
    @(negedge clk);
    lit("t6 in reset", {4'b0, rx_valid, rx_busy, framing_err, overrun}, 8'h00);
    lit("t6 data in reset", rx_data, 8'h00);
    step();
    reset_n = 1'b1;
    idle(20);
    @(negedge clk);
    lit("t6 after reset", {4'b0, rx_valid, rx_busy, framing_err, overrun}, 8'h00);
    step();
    send_frame(8'h07, 1'b1, -1);
    idle(2);
    @(negedge clk);
    lit("t6 frame after reset", rx_data, 8'h07);
    lit("t6 valid", {7'b0, rx_valid}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
